// File: rtl/tlb_pkg.sv
// -----------------------------------------------------------------------------
// tlb_pkg
// Shared definitions for the TLBIDX CSR and the TLB victim counter:
//   - TLBIDX field positions (INDEX, PS, NE) and the reset value
//   - search FSM state type
//   - default TLB depth
//   - writable_mask(): which TLBIDX bits software and hardware may change
// -----------------------------------------------------------------------------
package tlb_pkg;

   localparam int TLB_ENTRIES_DEF = 16;

   localparam int IDX_LSB = 0;
   localparam int PS_LSB  = 24;
   localparam int PS_W    = 6;
   localparam int NE_BIT  = 31;

   // NE set, everything else clear.
   localparam logic [31:0] TLBIDX_RST = 32'h8000_0000;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } srch_state_e;

   // Bits that exist in TLBIDX for a given index width; all others read 0.
   function automatic logic [31:0] writable_mask(input int idx_w);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 32; b++) begin
         if ((b >= IDX_LSB && b < IDX_LSB + idx_w) ||
             (b >= PS_LSB && b < PS_LSB + PS_W) ||
             (b == NE_BIT))
            m[b] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/tlb_victim_ctr.sv
// -----------------------------------------------------------------------------
// tlb_victim_ctr
// Wrapping victim-index counter for TLBFILL.
//   FILL_MODE 0: advances once per fill pulse.
//   FILL_MODE 1: advances every cycle (free-running pseudo-random victim).
// idx is the value to use for a fill in the current cycle (pre-increment).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears the counter
//   fill - TLBFILL executes this cycle
//   idx  - current victim index
// -----------------------------------------------------------------------------
module tlb_victim_ctr
   import tlb_pkg::*;
#(
   parameter  int ENTRIES   = TLB_ENTRIES_DEF,
   parameter  int FILL_MODE = 0,
   localparam int IDX_W     = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fill,
   output logic [IDX_W-1:0] idx
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

   logic advance;
   assign advance = (FILL_MODE != 0) ? 1'b1 : fill;

   // NOTE: registered state is written with non-blocking assignments so every
   // flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst)
         idx <= '0;
      else if (advance)
         idx <= (idx == LAST) ? '0 : idx + 1'b1;
   end

endmodule

// File: rtl/tlbidx_csr_unit.sv
// -----------------------------------------------------------------------------
// tlbidx_csr_unit
// TLBIDX CSR for LoongArch32 with TLBSRCH sequencing, TLBRD result capture
// and TLBFILL victim index generation.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   csr_we/csr_wmask/csr_wdata- masked CSR write (csrwr/csrxchg)
//   srch_start                - TLBSRCH issued (lookup request)
//   srch_busy                 - search outstanding
//   srch_done/srch_hit/
//   srch_hit_idx              - search response from the TLB array
//   tlbrd_valid/tlbrd_e/
//   tlbrd_ps                  - TLBRD result
//   tlbfill_valid             - TLBFILL executes this cycle
//   tlbidx                    - architectural TLBIDX
//   tlb_index                 - INDEX field, used by TLBRD/TLBWR
//   fill_idx                  - victim index for this cycle's TLBFILL
// Same-cycle priority (low to high): CSR write, search completion, TLBRD.
// -----------------------------------------------------------------------------
module tlbidx_csr_unit
   import tlb_pkg::*;
#(
   parameter  int TLB_ENTRIES = TLB_ENTRIES_DEF,
   parameter  int FILL_MODE   = 0,
   localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             csr_we,
   input  logic [31:0]      csr_wmask,
   input  logic [31:0]      csr_wdata,
   input  logic             srch_start,
   output logic             srch_busy,
   input  logic             srch_done,
   input  logic             srch_hit,
   input  logic [IDX_W-1:0] srch_hit_idx,
   input  logic             tlbrd_valid,
   input  logic             tlbrd_e,
   input  logic [5:0]       tlbrd_ps,
   input  logic             tlbfill_valid,
   output logic [31:0]      tlbidx,
   output logic [IDX_W-1:0] tlb_index,
   output logic [IDX_W-1:0] fill_idx
);

   localparam logic [31:0] WR_MASK = writable_mask(IDX_W);

   srch_state_e state_q, state_d;
   logic [31:0] tlbidx_q, tlbidx_d;
   logic        srch_complete;

   // A response only counts while a search is outstanding; a stray done in
   // IDLE (e.g. right after a reset aborted the search) is dropped.
   assign srch_complete = (state_q == WAIT) && srch_done;

   // ---------------- search FSM ----------------
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (srch_start) state_d = WAIT;
         WAIT: if (srch_done)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign srch_busy = (state_q == WAIT);

   // ---------------- TLBIDX register ----------------
   // Later assignments override earlier ones, giving the priority order.
   always_comb begin
      tlbidx_d = tlbidx_q;
      if (csr_we)
         tlbidx_d = (tlbidx_q & ~(csr_wmask & WR_MASK)) |
                    (csr_wdata & csr_wmask & WR_MASK);
      if (srch_complete) begin
         if (srch_hit) begin
            tlbidx_d[IDX_LSB +: IDX_W] = srch_hit_idx;
            tlbidx_d[NE_BIT]           = 1'b0;
         end else begin
            tlbidx_d[NE_BIT] = 1'b1;
         end
      end
      if (tlbrd_valid) begin
         tlbidx_d[PS_LSB +: PS_W] = tlbrd_e ? tlbrd_ps : '0;
         tlbidx_d[NE_BIT]         = ~tlbrd_e;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         tlbidx_q <= TLBIDX_RST;
      else
         tlbidx_q <= tlbidx_d;
   end

   assign tlbidx    = tlbidx_q;
   assign tlb_index = tlbidx_q[IDX_LSB +: IDX_W];

   // ---------------- victim counter ----------------
   tlb_victim_ctr #(
      .ENTRIES   (TLB_ENTRIES),
      .FILL_MODE (FILL_MODE)
   ) u_victim (
      .clk  (clk),
      .rst  (rst),
      .fill (tlbfill_valid),
      .idx  (fill_idx)
   );

   // A new search must not be issued while one is outstanding. Start together
   // with the completing done is tolerated: the done wins, the start drops.
   a_no_start_in_wait : assert property (
      @(posedge clk) disable iff (rst)
      !(state_q == WAIT && srch_start && !srch_done)
   );

endmodule

// File: doc/tlbidx_csr_unit.md
Name: tlbidx_csr_unit

Overview:
- Parametrised TLBIDX CSR for the LoongArch32 core, generalised to any power-of-two TLB depth.
- Holds TLBIDX.
- Sequences TLBSRCH through a two-state request/response handshake with the TLB array.
- Applies TLBRD results.
- Generates the TLBFILL victim index in round-robin or free-running mode.
- Sits in the CSR file next to TLBEHI/TLBELO and drives the index used by TLBRD/TLBWR.

Parameters:
- TLB_ENTRIES, 16, number of TLB entries; power of two, 2..64.
- IDX_W, $clog2(TLB_ENTRIES), index field width; derived, never overridden.
- FILL_MODE, 0, 0 = victim counter advances only on each TLBFILL; 1 = victim counter advances every cycle.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- csr_we  in  1  CSR write strobe for TLBIDX.
- csr_wmask  in  32  per-bit write mask from csrxchg (all ones for csrwr).
- csr_wdata  in  32  CSR write data.
- srch_start  in  1  TLBSRCH issued; lookup request to TLB array.
- srch_busy  out  1  search outstanding.
- srch_done  in  1  TLB array returns search result.
- srch_hit  in  1  search hit; valid with srch_done.
- srch_hit_idx  in  IDX_W  hit entry; valid with srch_done and srch_hit.
- tlbrd_valid  in  1  TLBRD result returned this cycle.
- tlbrd_e  in  1  E bit of the read entry.
- tlbrd_ps  in  6  PS of the read entry.
- tlbfill_valid  in  1  TLBFILL executes this cycle.
- tlbidx  out  32  architectural TLBIDX value.
- tlb_index  out  IDX_W  tlbidx[IDX_W-1:0], index for TLBRD/TLBWR.
- fill_idx  out  IDX_W  victim index for the TLBFILL executing this cycle.

Behaviour:
- Register layout:
  - [IDX_W-1:0] INDEX.
  - [29:24] PS.
  - [31] NE.
  - All other bits read 0 and ignore writes.
- Reset (rst high at a clk edge):
  - tlbidx = 32'h8000_0000.
  - Search FSM = IDLE, srch_busy = 0.
  - Victim counter = 0, so fill_idx = 0.
- CSR write: bit b is updated when csr_we && csr_wmask[b] && b is writable; otherwise the bit is held.
- Search FSM:
  - IDLE, srch_start: go to WAIT; srch_busy = 1 from the next cycle.
  - WAIT, srch_done: go to IDLE.
    - Hit: INDEX = srch_hit_idx, NE = 0.
    - Miss: NE = 1, INDEX unchanged.
    - PS is unchanged in both cases.
  - WAIT, srch_start: ignored; the pipeline must not issue it, and an assertion flags it.
  - IDLE, srch_done: ignored; nothing is updated.
  - srch_start and srch_done in the same cycle while in WAIT: the done is completed and the start is dropped.
- TLBRD (tlbrd_valid):
  - tlbrd_e = 1: PS = tlbrd_ps, NE = 0.
  - tlbrd_e = 0: PS = 0, NE = 1.
  - INDEX is always unchanged.
- Priority within one cycle, lowest to highest: CSR write, search completion, TLBRD. A higher-priority source overrides only the bits it updates.
- Victim counter:
  - IDX_W wide; wraps from TLB_ENTRIES-1 to 0.
  - FILL_MODE 0: increments on cycles with tlbfill_valid.
  - FILL_MODE 1: increments every cycle.
  - fill_idx shows the pre-increment value, so a TLBFILL uses the value seen in its own cycle.
- Latency: all updates are visible on tlbidx the cycle after the event. srch_busy rises the cycle after srch_start and falls the cycle after srch_done.
- Reset during WAIT: the FSM returns to IDLE. A srch_done in the following cycle is ignored.

Decomposition:
- Shared package tlb_pkg holds:
  - TLBIDX field bit positions (IDX_LSB, PS_LSB = 24, PS_W = 6, NE_BIT = 31).
  - The reset constant.
  - The search FSM state typedef (IDLE, WAIT).
  - The TLB_ENTRIES default.
- One sub-module is natural: tlb_victim_ctr, the wrapping counter with the FILL_MODE parameter. It is reused by a future multi-way TLB.

Test Plan:
- Reset, then read → tlbidx = 32'h8000_0000, srch_busy = 0, fill_idx = 0.
- TLB_ENTRIES = 16; csr_we with wdata 32'hFFFF_FFFF and full mask → tlbidx = 32'hBF00_000F. csr_wmask = 32'h0000_000F with wdata 0 → tlbidx = 32'hBF00_0000.
- srch_start; 3 cycles later srch_done, hit, idx = 5 → srch_busy = 1 for those cycles, then tlbidx = 32'h3F00_0005. A second search that misses → NE = 1, INDEX stays 5.
- tlbrd_valid with e = 1, ps = 12, in the same cycle as csr_we writing NE = 1 and PS = 21 → tlbidx[31] = 0, PS = 12. tlbrd with e = 0 → NE = 1, PS = 0.
- FILL_MODE 0, TLB_ENTRIES = 4: 5 tlbfill pulses with idle gaps → fill_idx sequence 0, 1, 2, 3, 0. FILL_MODE 1 → fill_idx steps by one every cycle.
- rst asserted while srch_busy = 1, then srch_done with hit idx = 3 → srch_busy = 0 and tlbidx stays 32'h8000_0000.
